eai_wb_ring_buf: RTL and testbench



---
 rtl/eai_wb_pkg.sv | 21 ++
 rtl/eai_wb_idx_match.sv | 38 +++
 rtl/eai_wb_ring_buf.sv | 128 ++++++++++++
 tb/tb_eai_wb_ring_buf.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/eai_wb_pkg.sv
// ---------------------------------------------------------------------------
// eai_wb_pkg
// Shared constants and types for the EAI write-back path.
//   EAI_WB_DW    : default write-back data width
//   EAI_WB_DEPTH : default number of ring entries
//   EAI_WB_IDXW  : default destination register index width
//   eai_wb_entry_t : packed {valid, idx, data} entry at the default widths
// ---------------------------------------------------------------------------
package eai_wb_pkg;

    localparam int EAI_WB_DW    = 32;
    localparam int EAI_WB_DEPTH = 4;
    localparam int EAI_WB_IDXW  = 5;

    typedef struct packed {
        logic                   valid;
        logic [EAI_WB_IDXW-1:0] idx;
        logic [EAI_WB_DW-1:0]   data;
    } eai_wb_entry_t;

endpackage : eai_wb_pkg

// File: rtl/eai_wb_idx_match.sv
// ---------------------------------------------------------------------------
// eai_wb_idx_match
// Reports whether any valid entry targets a given register index. Purely
// combinational; shared by the EAI hazard checks.
// Ports:
//   valid    [DEPTH]        : per-entry valid bits
//   idx_flat [DEPTH*IDXW]   : per-entry destination indices, entry i at bits
//                             [i*IDXW +: IDXW]
//   chk_idx  [IDXW]         : index to look up
//   hit      [1]            : some valid entry holds chk_idx
// ---------------------------------------------------------------------------
module eai_wb_idx_match #(
    parameter int DEPTH = 4,
    parameter int IDXW  = 5
) (
    input  logic [DEPTH-1:0]      valid,
    input  logic [DEPTH*IDXW-1:0] idx_flat,
    input  logic [IDXW-1:0]       chk_idx,
    output logic                  hit
);

    logic hit_s;

    // OR-reduce the per-entry valid & index-equal terms
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (idx_flat[i*IDXW +: IDXW] == chk_idx)) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    assign hit = hit_s;

endmodule : eai_wb_idx_match

// File: rtl/eai_wb_ring_buf.sv
// ---------------------------------------------------------------------------
// eai_wb_ring_buf
// In-order DEPTH-entry write-back ring between the EAI execution unit and the
// core write-back stage. Each entry holds {valid, destination index, data}.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   flush             : discard all held entries (payload kept, valids cleared)
//   wr_valid/wr_ready : producer handshake; wr_wb_data, wr_rd_idx payload
//   rd_valid/rd_ready : consumer handshake; rd_wb_data, rd_rd_idx show the
//                       oldest entry (meaningless while rd_valid=0)
//   count             : entries held
//   almost_full       : count >= DEPTH-AF_MARGIN
//   chk_rd_idx/chk_hit: pending-destination lookup over held entries
// ---------------------------------------------------------------------------
module eai_wb_ring_buf
    import eai_wb_pkg::*;
#(
    parameter int DW        = EAI_WB_DW,
    parameter int DEPTH     = EAI_WB_DEPTH,
    parameter int IDXW      = EAI_WB_IDXW,
    parameter int AF_MARGIN = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DW-1:0]            wr_wb_data,
    input  logic [IDXW-1:0]          wr_rd_idx,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DW-1:0]            rd_wb_data,
    output logic [IDXW-1:0]          rd_rd_idx,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    input  logic [IDXW-1:0]          chk_rd_idx,
    output logic                     chk_hit
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]      ent_valid_r;
    logic [IDXW-1:0]       ent_idx_r  [DEPTH];
    logic [DW-1:0]         ent_data_r [DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;

    logic                  wr_ready_s;
    logic                  rd_valid_s;
    logic                  wr_hs_s;
    logic                  rd_hs_s;
    logic [DEPTH*IDXW-1:0] idx_flat_s;

    // Readiness depends only on stored occupancy and flush, never on rd_ready,
    // so a full ring does not admit a write in the cycle a read frees a slot.
    assign wr_ready_s = (count_r != CW'(DEPTH)) & ~flush;
    assign rd_valid_s = (count_r != CW'(0)) & ~flush;
    assign wr_hs_s    = wr_valid & wr_ready_s;
    assign rd_hs_s    = rd_valid_s & rd_ready;

    assign wr_ready    = wr_ready_s;
    assign rd_valid    = rd_valid_s;
    assign rd_wb_data  = ent_data_r[rd_ptr_r];
    assign rd_rd_idx   = ent_idx_r[rd_ptr_r];
    assign count       = count_r;
    assign almost_full = (count_r >= CW'(DEPTH - AF_MARGIN));

    // Pack the stored indices for the shared match block
    always_comb begin
        idx_flat_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_flat_s[i*IDXW +: IDXW] = ent_idx_r[i];
        end
    end

    // Hazard lookup covers stored entries only: not the write arriving this
    // cycle, but still the entry leaving this cycle, and flush does not mask it
    eai_wb_idx_match #(
        .DEPTH (DEPTH),
        .IDXW  (IDXW)
    ) u_idx_match (
        .valid    (ent_valid_r),
        .idx_flat (idx_flat_s),
        .chk_idx  (chk_rd_idx),
        .hit      (chk_hit)
    );

    // Entry storage, pointers and occupancy; reset beats flush beats handshakes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_valid_r <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_idx_r[i]  <= '0;
                ent_data_r[i] <= '0;
            end
        end else if (flush) begin
            // Payload is deliberately kept; only bookkeeping is cleared
            ent_valid_r <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
        end else begin
            if (rd_hs_s) begin
                ent_valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r              <= rd_ptr_r + PW'(1);
            end
            // A write can never target the slot being read: with a read in
            // flight the ring is non-empty and not full-and-writable at once
            if (wr_hs_s) begin
                ent_valid_r[wr_ptr_r] <= 1'b1;
                ent_idx_r[wr_ptr_r]   <= wr_rd_idx;
                ent_data_r[wr_ptr_r]  <= wr_wb_data;
                wr_ptr_r              <= wr_ptr_r + PW'(1);
            end
            case ({wr_hs_s, rd_hs_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule : eai_wb_ring_buf

// File: tb/tb_eai_wb_ring_buf.sv
// ---------------------------------------------------------------------------
// tb_eai_wb_ring_buf
// Directed and random stimulus for eai_wb_ring_buf (DEPTH=4, AF_MARGIN=1).
// A queue scoreboard models the ring: accepted writes are pushed, and the
// monitor pops and compares on every read handshake, while also checking
// readiness, count, almost_full and chk_hit each cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eai_wb_ring_buf;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int IDXW  = 5;
    localparam int AFM   = 1;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            wr_valid;
    logic            wr_ready;
    logic [DW-1:0]   wr_wb_data;
    logic [IDXW-1:0] wr_rd_idx;
    logic            rd_valid;
    logic            rd_ready;
    logic [DW-1:0]   rd_wb_data;
    logic [IDXW-1:0] rd_rd_idx;
    logic [2:0]      count;
    logic            almost_full;
    logic [IDXW-1:0] chk_rd_idx;
    logic            chk_hit;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic [DW-1:0]   data;
    } exp_t;

    exp_t sb_q[$];

    eai_wb_ring_buf #(
        .DW        (DW),
        .DEPTH     (DEPTH),
        .IDXW      (IDXW),
        .AF_MARGIN (AFM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_wb_data  (wr_wb_data),
        .wr_rd_idx   (wr_rd_idx),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_wb_data  (rd_wb_data),
        .rd_rd_idx   (rd_rd_idx),
        .count       (count),
        .almost_full (almost_full),
        .chk_rd_idx  (chk_rd_idx),
        .chk_hit     (chk_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare on the falling edge, then advance the model
    // to what the coming rising edge should do.
    always @(negedge clk) begin
        logic exp_wr_ready;
        logic exp_rd_valid;
        logic exp_hit;
        exp_t head;
        exp_wr_ready = (sb_q.size() != DEPTH) && !flush;
        exp_rd_valid = (sb_q.size() != 0) && !flush;
        exp_hit = 1'b0;
        foreach (sb_q[i]) begin
            if (sb_q[i].idx == chk_rd_idx) exp_hit = 1'b1;
        end
        check("wr_ready", 64'(wr_ready), 64'(exp_wr_ready));
        check("rd_valid", 64'(rd_valid), 64'(exp_rd_valid));
        check("count", 64'(count), 64'(sb_q.size()));
        check("almost_full", 64'(almost_full), 64'(sb_q.size() >= DEPTH - AFM));
        check("chk_hit", 64'(chk_hit), 64'(exp_hit));
        if (!rst_n || flush) begin
            sb_q.delete();
        end else begin
            if (exp_rd_valid && rd_ready) begin
                head = sb_q.pop_front();
                check("rd_rd_idx", 64'(rd_rd_idx), 64'(head.idx));
                check("rd_wb_data", 64'(rd_wb_data), 64'(head.data));
            end
            if (wr_valid && exp_wr_ready) begin
                sb_q.push_back({wr_rd_idx, wr_wb_data});
            end
        end
    end

    // Drive one cycle of inputs, then step to just after the next rising edge
    task automatic cyc(input logic wv, input logic [IDXW-1:0] idx, input logic [DW-1:0] data,
                       input logic rr, input logic fl);
        wr_valid   = wv;
        wr_rd_idx  = idx;
        wr_wb_data = data;
        rd_ready   = rr;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        wr_wb_data = '0; wr_rd_idx = '0; chk_rd_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_wr_ready", 64'(wr_ready), 64'd1);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_almost_full", 64'(almost_full), 64'd0);
        check("rst_chk_hit", 64'(chk_hit), 64'd0);
        check("rst_rd_wb_data", 64'(rd_wb_data), 64'd0);
        check("rst_rd_rd_idx", 64'(rd_rd_idx), 64'd0);

        // Two writes, no reads; first visible one cycle later
        cyc(1'b1, 5'd3, 32'hA5A5_0001, 1'b0, 1'b0);
        check("t1_rd_valid", 64'(rd_valid), 64'd1);
        check("t1_rd_idx", 64'(rd_rd_idx), 64'd3);
        check("t1_rd_data", 64'(rd_wb_data), 64'hA5A5_0001);
        cyc(1'b1, 5'd7, 32'h0000_0002, 1'b0, 1'b0);
        wr_valid = 1'b0;
        check("t1_count", 64'(count), 64'd2);
        chk_rd_idx = 5'd7; #1;
        check("t1_hit7", 64'(chk_hit), 64'd1);
        chk_rd_idx = 5'd4; #1;
        check("t1_hit4", 64'(chk_hit), 64'd0);

        // Fill to 4; a read while full does not admit the waiting write
        cyc(1'b1, 5'd0, 32'h0000_0003, 1'b0, 1'b0);
        check("t2_count3", 64'(count), 64'd3);
        check("t2_af3", 64'(almost_full), 64'd1);
        cyc(1'b1, 5'd1, 32'h0000_0004, 1'b0, 1'b0);
        check("t2_count4", 64'(count), 64'd4);
        check("t2_full_wr_ready", 64'(wr_ready), 64'd0);
        cyc(1'b1, 5'd9, 32'h0000_0099, 1'b1, 1'b0);
        check("t2_after_read_count", 64'(count), 64'd3);
        cyc(1'b1, 5'd9, 32'h0000_0099, 1'b0, 1'b0);
        check("t2_refill_count", 64'(count), 64'd4);
        repeat (4) cyc(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        check("t2_drained", 64'(count), 64'd0);

        // Stream 10 writes with continuous reads; pointers wrap
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 5'(i + 16), 32'hBEEF_0000 + 32'(i), 1'b1, 1'b0);
            check("t3_count", 64'(count), 64'd1);
        end
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        check("t3_empty", 64'(count), 64'd0);

        // Flush with count=3 while both sides try to handshake
        for (int i = 0; i < 3; i++) cyc(1'b1, 5'(i + 2), 32'hF000_0000 + 32'(i), 1'b0, 1'b0);
        wr_valid = 1'b1; rd_ready = 1'b1; flush = 1'b1; #1;
        check("t4_flush_wr_ready", 64'(wr_ready), 64'd0);
        check("t4_flush_rd_valid", 64'(rd_valid), 64'd0);
        cyc(1'b1, 5'd6, 32'hDEAD_0006, 1'b1, 1'b1);
        check("t4_count", 64'(count), 64'd0);
        for (int i = 0; i < 32; i++) begin
            chk_rd_idx = 5'(i);
            cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        end
        cyc(1'b1, 5'd12, 32'h0000_000C, 1'b0, 1'b0);
        check("t4_post_idx", 64'(rd_rd_idx), 64'd12);
        check("t4_post_data", 64'(rd_wb_data), 64'h0000_000C);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

        // Reset mid-operation with a write pending
        cyc(1'b1, 5'd8, 32'h1111_0008, 1'b0, 1'b0);
        cyc(1'b1, 5'd9, 32'h1111_0009, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc(1'b1, 5'd10, 32'h1111_000A, 1'b0, 1'b0);
        rst_n = 1'b1;
        check("t5_count", 64'(count), 64'd0);
        check("t5_rd_valid", 64'(rd_valid), 64'd0);
        check("t5_rd_data", 64'(rd_wb_data), 64'd0);

        // Random valid/ready traffic with occasional flush
        for (int i = 0; i < 2000; i++) begin
            chk_rd_idx = 5'($urandom_range(0, 7));
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
        end
        repeat (6) cyc(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        check("final_empty", 64'(count), 64'd0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_eai_wb_ring_buf
